// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser plus per-key counter debounce FSM producing press/release pulses and a level.
// Define LONG_PRESS_EN to add a one-shot key_long pulse after LONG_CNT held cycles; otherwise key_long is tied low.
module key_debounce #(
    parameter int unsigned KEY_NUM  = 2,
    parameter int unsigned DEB_CNT  = 240000,
    parameter int unsigned LONG_CNT = 12000000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_raw,
    output logic [KEY_NUM-1:0] key_pulse,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_long
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
`else
    // LONG_CNT has no function without the long-press feature
    logic unused_long_cnt;
    assign unused_long_cnt = ^32'(LONG_CNT);
`endif

    logic [KEY_NUM-1:0] meta_q;
    logic [KEY_NUM-1:0] sync_q;

    // Synchroniser resets to the released level so no press is seen out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= key_raw;
            sync_q <= meta_q;
        end
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pulse_q, pulse_d;
        logic             release_q, release_d;
        logic             level_q, level_d;
        logic             released;

        assign released = sync_q[k];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                pulse_q   <= 1'b0;
                release_q <= 1'b0;
                level_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                pulse_q   <= pulse_d;
                release_q <= release_d;
                level_q   <= level_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!released) begin
                        state_d = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (released) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (released) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end else begin
`ifdef LONG_PRESS_EN
                        if (cnt_q != LONG_LAST) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
`else
                        cnt_d = '0;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back low restarts the hold count from zero
                    if (!released) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Pulses and level are decoded from the transition so they land in the same cycle
        always_comb begin
            pulse_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
            release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
            level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        end

        assign key_pulse[k]   = pulse_q;
        assign key_release[k] = release_q;
        assign key_state[k]   = level_q;

`ifdef LONG_PRESS_EN
        logic long_q, long_d;
        logic long_done_q, long_done_d;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                long_q      <= 1'b0;
                long_done_q <= 1'b0;
            end else begin
                long_q      <= long_d;
                long_done_q <= long_done_d;
            end
        end

        // Counter saturates at LONG_LAST; the done flag limits the pulse to once per hold
        always_comb begin
            long_d      = (state_q == PRESSED) && (state_d == PRESSED) &&
                          (cnt_q == LONG_LAST) && !long_done_q;
            long_done_d = (state_q == PRESSED) && (state_d == PRESSED) &&
                          (long_done_q || long_d);
        end

        assign key_long[k] = long_q;
`else
        assign key_long[k] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed latency/bounce/reset scenarios then random key activity,
// checked every cycle against a run-length model of the debounce rules.
module tb_key_debounce;

    localparam int unsigned KEY_NUM  = 2;
    localparam int unsigned DEB_CNT  = 8;
    localparam int unsigned LONG_CNT = 40;
    localparam int unsigned CNT_W    = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [KEY_NUM-1:0] key_raw = '1;
    logic [KEY_NUM-1:0] key_pulse;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] key_long;

    key_debounce #(
        .KEY_NUM (KEY_NUM),
        .DEB_CNT (DEB_CNT),
        .LONG_CNT(LONG_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .key_pulse  (key_pulse),
        .key_release(key_release),
        .key_state  (key_state),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: level flips once the synchronised input has disagreed with it for DEB_CNT+1 straight samples
    logic [1:0] m_p1 = '1;
    logic [1:0] m_p2 = '1;
    bit         m_lvl  [2];
    int         m_run  [2];
    int         m_held [2];
    logic [1:0] exp_pulse = '0;
    logic [1:0] exp_rel   = '0;
    logic [1:0] exp_state = '0;
    logic [1:0] exp_long  = '0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_p1 = '1;
            m_p2 = '1;
            exp_pulse = '0;
            exp_rel   = '0;
            exp_state = '0;
            exp_long  = '0;
            for (int k = 0; k < 2; k++) begin
                m_lvl[k]  = 1'b0;
                m_run[k]  = 0;
                m_held[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit pin;
                pin = !m_p2[k];
                exp_pulse[k] = 1'b0;
                exp_rel[k]   = 1'b0;
                exp_long[k]  = 1'b0;
                if (pin != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == int'(DEB_CNT) + 1) begin
                        m_lvl[k]     = pin;
                        exp_pulse[k] = pin;
                        exp_rel[k]   = !pin;
                        m_run[k]     = 0;
                        m_held[k]    = 0;
                    end
                end else begin
                    if (m_lvl[k]) begin
                        if (m_run[k] > 0) m_held[k] = 0;
                        else m_held[k]++;
`ifdef LONG_PRESS_EN
                        if (m_held[k] == int'(LONG_CNT)) exp_long[k] = 1'b1;
`endif
                    end
                    m_run[k] = 0;
                end
                exp_state[k] = m_lvl[k];
            end
            m_p2 = m_p1;
            m_p1 = key_raw;
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            checks++;
            if ({key_pulse, key_release, key_state, key_long} !== {exp_pulse, exp_rel, exp_state, exp_long}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got p=%b r=%b s=%b l=%b expected p=%b r=%b s=%b l=%b",
                         $time, key_pulse, key_release, key_state, key_long,
                         exp_pulse, exp_rel, exp_state, exp_long);
            end
        end
    end

    // Event counters and cycle stamps for the directed checks
    int cyc = 0;
    int n_pulse [2];
    int n_rel   [2];
    int n_long  [2];
    int last_pulse_cyc [2];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (key_pulse[k] === 1'b1) begin
                n_pulse[k]++;
                last_pulse_cyc[k] = cyc;
            end
            if (key_release[k] === 1'b1) n_rel[k]++;
            if (key_long[k] === 1'b1) n_long[k]++;
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic out_bit(input int sel, input int k);
        case (sel)
            0:       return key_pulse[k];
            1:       return key_release[k];
            default: return key_long[k];
        endcase
    endfunction

    // Returns the edge index (1-based) after which the selected output first goes high, -1 on timeout
    task automatic wait_event(input int sel, input int k, input int max_edges, output int idx);
        idx = -1;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clk);
            #1;
            if (out_bit(sel, k) === 1'b1) begin
                idx = i;
                break;
            end
        end
    endtask

    task automatic hold(input logic [1:0] v, input int n);
        key_raw = v;
        repeat (n) @(negedge clk);
    endtask

    int idx;
    int p0, r0, l0, t0;
    int rem [2];

    initial begin
        rst = 1'b0;
        key_raw = '1;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        #1;
        check("reset_outputs", int'({key_pulse, key_release, key_state, key_long}), 0);
        @(negedge clk);
        rst = 1'b1;
        hold(2'b11, 4);

        // Clean press and release on key 0
        key_raw = 2'b10;
        wait_event(0, 0, 20, idx);
        check("press_latency", idx, 11);
        check("press_state", int'(key_state), 1);
        @(negedge clk);
        key_raw = 2'b11;
        wait_event(1, 0, 20, idx);
        check("release_latency", idx, 11);
        check("release_state", int'(key_state), 0);

        // Press bounce: low 3, high 2, low 4, then high
        @(negedge clk);
        #1;
        p0 = n_pulse[0];
        hold(2'b10, 3);
        hold(2'b11, 2);
        hold(2'b10, 4);
        hold(2'b11, 20);
        #1;
        check("bounce_pulses", n_pulse[0] - p0, 0);
        check("bounce_state", int'(key_state[0]), 0);

        // Release bounce of 5 cycles after an accepted press
        hold(2'b10, 15);
        #1;
        check("rb_press_state", int'(key_state[0]), 1);
        p0 = n_pulse[0];
        r0 = n_rel[0];
        hold(2'b11, 5);
        hold(2'b10, 30);
        #1;
        check("rb_no_release", n_rel[0] - r0, 0);
        check("rb_no_extra_pulse", n_pulse[0] - p0, 0);
        check("rb_state", int'(key_state[0]), 1);
        hold(2'b11, 15);
        #1;
        check("rb_final_release", n_rel[0] - r0, 1);

        // Long hold
        key_raw = 2'b10;
        wait_event(0, 0, 20, idx);
        check("long_press_latency", idx, 11);
`ifdef LONG_PRESS_EN
        wait_event(2, 0, 60, idx);
        check("long_latency", idx, 40);
        @(negedge clk);
        #1;
        l0 = n_long[0];
        repeat (20) @(negedge clk);
        #1;
        check("long_single", n_long[0] - l0, 0);
`else
        repeat (60) @(negedge clk);
        #1;
        check("long_off", n_long[0], 0);
`endif
        @(negedge clk);
        hold(2'b11, 15);

        // Both keys on the same edge, then key 1 staggered by 3 cycles
        key_raw = 2'b00;
        wait_event(0, 0, 20, idx);
        check("dual_latency", idx, 11);
        check("dual_pulse", int'(key_pulse), 3);
        @(negedge clk);
        hold(2'b11, 15);
        t0 = cyc;
        hold(2'b10, 3);
        hold(2'b00, 15);
        #1;
        check("stagger_k0", last_pulse_cyc[0] - t0, 11);
        check("stagger_k1", last_pulse_cyc[1] - last_pulse_cyc[0], 3);

        // Reset while key 0 is mid-debounce and key 1 is held
        hold(2'b11, 15);
        hold(2'b01, 15);
        key_raw = 2'b00;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_state", int'(key_state), 2);
        #1;
        rst = 1'b0;
        #1;
        check("rst_outputs", int'({key_pulse, key_release, key_state, key_long}), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_event(0, 0, 20, idx);
        check("post_rst_latency", idx, 11);
        check("post_rst_dual", int'(key_pulse), 3);
        @(negedge clk);
        hold(2'b11, 15);

        // Random activity with mixed short (bounce) and long runs, plus two async resets
        rem[0] = 1;
        rem[1] = 1;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (rem[k] == 0) begin
                    key_raw[k] = ~key_raw[k];
                    rem[k] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 12))
                                                         : int'($urandom_range(13, 60));
                end
                rem[k]--;
            end
            if (i == 1500 || i == 2900) begin
                #2;
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        hold(2'b11, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
Debounces and edge-detects the board push-buttons that drive the safe box's open/close key and alarm-clear key. Each raw active-low button input gets a 2-FF synchroniser and an independent counter-based debounce state machine. The block produces a clean one-cycle press pulse, a one-cycle release pulse and a stable level per key. It sits directly upstream of the safe-box controller, whose key_pulse and ce inputs are fed from key_pulse[0] and key_state[1].

Parameters:
KEY_NUM, 2, number of independent buttons
DEB_CNT, 240000, stable-level cycles required to accept a change (20 ms at 12 MHz)
LONG_CNT, 12000000, held cycles before a long-press pulse (1 s at 12 MHz); used only with the optional feature
CNT_W, 24, counter width; must satisfy 2^CNT_W > max(DEB_CNT, LONG_CNT)

Ports:
clk  input  1  system clock, 12 MHz
rst  input  1  asynchronous, active-low reset
key_raw  input  KEY_NUM  raw button pins, active-low (0 = pressed), asynchronous to clk
key_pulse  output  KEY_NUM  one-cycle high pulse on accepted press
key_release  output  KEY_NUM  one-cycle high pulse on accepted release
key_state  output  KEY_NUM  debounced level, 1 = pressed
key_long  output  KEY_NUM  one-cycle high pulse on long press; constant 0 when feature is disabled

Behaviour:
- Reset is asynchronous and active-low, on port rst, with clock clk. While rst=0:
  - synchroniser FFs = 1 (released); all FSMs in IDLE; all counters = 0.
  - key_pulse, key_release, key_state and key_long = 0.
  - Reset mid-press aborts the press; no pulse is emitted on exit from reset.
- Synchroniser: 2 flops per key. sync = second flop output.
- Per-key FSM, each key fully independent. Simultaneous events on different keys are handled in the same cycle.
  - IDLE: if sync=0, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT: if sync=1, return to IDLE (bounce rejected, no output). Otherwise cnt++. When cnt==DEB_CNT-1, go to PRESSED, set cnt=0, and register key_pulse=1 for exactly one cycle.
  - PRESSED: if sync=1, go to RELEASE_WAIT and set cnt=0. Otherwise cnt saturates at LONG_CNT-1 (feature on) or holds at 0 (feature off).
  - RELEASE_WAIT: if sync=0, return to PRESSED (bounce on release; no key_pulse; long-press count restarts from 0). Otherwise cnt++. When cnt==DEB_CNT-1, go to IDLE and register key_release=1 for one cycle.
- key_state = 1 in PRESSED and RELEASE_WAIT, 0 otherwise. It is registered and changes in the same cycle as the corresponding pulse.
- Latency: raw low first sampled at edge 1 gives key_pulse high in the cycle following edge DEB_CNT+3, provided raw stays low. Release latency is identical, DEB_CNT+3 edges.
- Any glitch shorter than DEB_CNT cycles after synchronisation produces no output change.
- Exactly one key_pulse and one key_release per accepted press/release pair; they are never asserted together for the same key.
- Counters never wrap: they compare on ==, then clear.

Optional Feature:
LONG_PRESS_EN
- Defined:
  - In PRESSED, cnt counts while held.
  - On reaching LONG_CNT-1, key_long=1 for one cycle and cnt saturates, so only one key_long per press.
  - A release bounce back to PRESSED restarts the count.
- Undefined:
  - key_long is tied to 0.
  - The long-press compare logic is removed; LONG_CNT is ignored.

Test Plan:
- Simulation uses DEB_CNT=8, LONG_CNT=40, CNT_W=8.
- Clean press: key_raw[0] 1->0 before edge 1, held -> key_pulse[0]=1 for the single cycle after edge 11; key_state[0]=1 from then on.
- Bounce: key_raw[0] toggles low 3 cycles, high 2, low 4, high -> no key_pulse, key_state stays 0; the FSM returns to IDLE.
- Release: after an accepted press, raw 0->1 and held -> key_release[0]=1 one cycle, 11 edges later; key_state[0]=0; release bounce of 5 cycles -> no key_release and no extra key_pulse.
- Two keys: key_raw=2'b11->2'b00 on the same edge -> key_pulse=2'b11 in the same cycle. Stagger key 1 by 3 cycles -> its pulse is 3 cycles later.
- Reset mid-operation: rst=0 while key 0 is in PRESS_WAIT (cnt=5) -> all outputs 0 immediately. Release rst with raw still low -> a full new DEB_CNT+3 latency before key_pulse.
- LONG_PRESS_EN defined, hold 60 cycles after key_pulse -> exactly one key_long pulse, 40 cycles after entering PRESSED. Undefined -> key_long stays 0.
